// File: rtl/ps2_key_event.sv
// PS/2 keyboard receiver: frames raw PS/2 bits, decodes E0/F0 prefixes into
// {ext, break, code} events, queues them in a FIFO and tracks the held key.
`timescale 1ns/1ps
module ps2_key_event #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             ev_pop,
    output logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] press_count,
    output logic             key_held,
    output logic [8:0]       held_code
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_t;

    // ---------------- synchronisers and falling-edge detect ----------------
    logic clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
    logic sample;

    // NOTE: synchroniser flops reset to the PS/2 idle level (1) so that
    // releasing reset never fabricates a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    assign sample = clk_prev & ~clk_sync;

    // ---------------- frame assembly, checking and timeout ----------------
    logic [9:0]      shreg;
    logic [3:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            byte_stb;
    logic [7:0]      byte_q;
    logic [10:0]     frame;
    logic            frame_ok;
    logic            last_bit;
    logic            proto_err;

    assign frame    = {dat_sync, shreg};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    assign last_bit = sample && (bit_cnt == 4'd10);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            byte_stb  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= last_bit && frame_ok;
            frame_err <= (last_bit && !frame_ok) || proto_err;
            if (sample) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    byte_q  <= frame[8:1];
                end else begin
                    shreg   <= {dat_sync, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                // Stalled partial frame: drop it silently.
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // ---------------- prefix decoder FSM ----------------
    dec_state_t state_q, state_d;
    logic       emit, emit_ext, emit_brk;
    logic       push_req;
    logic [9:0] push_data;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            state_q   <= state_d;
            push_req  <= emit;
            push_data <= {emit_ext, emit_brk, byte_q};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        proto_err = 1'b0;
        if (byte_stb) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hE0)      state_d = S_EXT;
                    else if (byte_q == 8'hF0) state_d = S_BRK;
                    else                      emit    = 1'b1;
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d   = S_IDLE;
                        proto_err = (byte_q == 8'hE0);
                        emit      = (byte_q != 8'hE0);
                        emit_ext  = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d   = S_IDLE;
                    proto_err = (byte_q == 8'hE0) || (byte_q == 8'hF0);
                    emit      = !proto_err;
                    emit_ext  = (state_q == S_EXT_BRK);
                    emit_brk  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- event FIFO and held-key tracking ----------------
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, do_pop, do_push;
    logic [8:0]  ev_key;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ev_pop && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ev_key  = {push_data[9], push_data[7:0]};

    // NOTE: storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            press_count <= '0;
            key_held    <= 1'b0;
            held_code   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !do_push) overflow <= 1'b1;
            if (push_req) begin
                if (!push_data[8]) begin
                    if (!key_held || ev_key != held_code) begin
                        press_count <= press_count + 1'b1;
                        key_held    <= 1'b1;
                        held_code   <= ev_key;
                    end
                end else if (ev_key == held_code) begin
                    key_held <= 1'b0;
                end
            end
        end
    end

    assign ev_ready = !empty;
    assign ev_code  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]][7:0];
    assign ev_ext   = !empty && mem[rd_ptr[AW-1:0]][9];
    assign ev_break = !empty && mem[rd_ptr[AW-1:0]][8];

endmodule
